rob_banked_multi: RTL and testbench
===================================

# rob_banked_multi

Parametrised reorder buffer for the rename stage. It holds in-flight instructions in program order, takes a configurable number of dispatches per cycle, and accepts out-of-order completion on several writeback ports. It retires up to RETIRE_WIDTH completed entries per cycle from the head, in order, and reports exceptions precisely. On flush it restores itself to empty in one cycle. It sits between rename/dispatch (allocation), the writeback network (completion) and the retire/commit logic (drain), and adds depth, width, port count and exception handling as parameters.

## Interface
- DEPTH, 32: entry count; power of two, ≥ 2·max(DISPATCH_WIDTH, RETIRE_WIDTH).
- DISPATCH_WIDTH, 4: allocations per cycle.
- RETIRE_WIDTH, 4: retirements per cycle.
- WB_PORTS, 4: completion ports.
- PAYLOAD_W, 64: opaque per-entry payload (pc, dst preg, old preg, ...).
- IDX_W, $clog2(DEPTH): entry index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- disp_valid  in  DISPATCH_WIDTH  lane-valid; must be a contiguous prefix from lane 0.
- disp_payload  in  DISPATCH_WIDTH×PAYLOAD_W  per-lane payload.
- disp_ready  out  1  high when free entries ≥ DISPATCH_WIDTH.
- disp_idx  out  DISPATCH_WIDTH×IDX_W  index given to lane i, equal to (tail+i) mod DEPTH.
- wb_valid  in  WB_PORTS  completion strobe.
- wb_idx  in  WB_PORTS×IDX_W  completing entry.
- wb_exc  in  WB_PORTS  completion raised an exception.
- ret_valid  out  RETIRE_WIDTH  retiring lanes; always a contiguous prefix.
- ret_payload  out  RETIRE_WIDTH×PAYLOAD_W  payload of the retiring lanes.
- ret_idx  out  RETIRE_WIDTH×IDX_W  index of the retiring lanes.
- ret_ready  in  1  retire consumer accepts this cycle.
- exc_valid  out  1  head entry is complete with an exception.
- exc_payload  out  PAYLOAD_W  payload of the head entry.
- flush  in  1  discard all entries.
- count  out  IDX_W+1  occupied entries.
- empty, full  out  1  status flags.

## Operation
- head and tail pointers are IDX_W+1 bits; the MSB is the wrap bit. Empty is head==tail. Full is equal low bits with a differing wrap bit. count = tail−head, modulo 2^(IDX_W+1).
- Per-entry state: valid, complete, exc, payload.
- Dispatch fires when disp_valid[0] && disp_ready. Lanes with disp_valid set write valid=1, complete=0, exc=0 and the payload at tail+i. tail advances by popcount(disp_valid). Dispatch while not ready is dropped; the upstream stage must stall.
- Writeback: each wb_valid port sets complete=1 at wb_idx, and sets exc if wb_exc is set. Writeback to an entry with valid=0 is ignored. Two ports hitting the same index OR their exc bits.
- Retire: lane j is eligible if entry head+j is valid and complete, has exc=0, and lanes 0..j−1 are all eligible. ret_valid is the eligible prefix and is combinational from registered state. When ret_ready=1, eligible entries are cleared (valid=0) and head advances by popcount(ret_valid).
- Exception: if the head entry is valid, complete and has exc=1, then exc_valid=1, exc_payload shows the head payload and ret_valid=0. This holds until flush. Entries younger than an excepting entry never retire past it.
- Flush: head=tail=0 and all valid/complete/exc bits cleared. Flush has priority over same-cycle dispatch, writeback and retire.
- reset: identical to flush. Outputs after reset: disp_ready=1, ret_valid=0, exc_valid=0, count=0, empty=1, full=0, disp_idx[i]=i.

## Timing
- Dispatch in cycle N: the entries are visible, and count is updated, in cycle N+1.
- Writeback in cycle N: the entry can retire in cycle N+1 at the earliest. There is no same-cycle bypass.
- disp_ready uses the registered count only. A same-cycle retire gives no credit, so free space is counted conservatively.
- Dispatch and retire in the same cycle are legal; count changes by dispatched − retired.
- Pointers wrap modulo DEPTH. Retire and writeback lanes index across the wrap point correctly, e.g. head=30 retires 30, 31, 0, 1.
- Reset or flush during a partial dispatch, writeback or retire: the whole cycle's update is discarded.

## Test plan
- Reset, then dispatch 4 lanes × 8 cycles with DEPTH=32 → full=1, disp_ready=0, count=32; a ninth dispatch is dropped and tail is unchanged.
- Dispatch idx 0–3, then writeback 3, 1, 2 in one cycle → ret_valid=0000. Writeback 0 → next cycle ret_valid=1111 with ret_idx 0,1,2,3; after ret_ready=1, empty=1.
- Writeback idx 0 and 2 only → ret_valid=0001; the following cycle ret_valid=0000 until idx 1 completes.
- Dispatch 3, writeback idx 1 with exc=1 and idx 0, 2 normally → cycle 1: ret_valid=0001 (idx 0). Cycle 2: exc_valid=1 with payload of idx 1, ret_valid=0. Flush → count=0, exc_valid=0.
- Wrap: advance head and tail to 30, dispatch 4, complete all → ret_idx 30, 31, 0, 1 and wrap bits toggle; count stays correct.
- Simultaneous dispatch 4 / retire 4 at count=28 → count stays 28, and disp_ready is asserted from the registered count.

Source files
------------

// File: rtl/rob_banked_multi.sv
// rob_banked_multi: parametrised reorder buffer. Holds in-flight instructions in
// program order, allocates up to DISPATCH_WIDTH entries per cycle, accepts
// out-of-order completion on WB_PORTS writeback ports and retires up to
// RETIRE_WIDTH completed entries per cycle from the head. An excepting head
// entry blocks retirement until flush. Reset and flush both restore the buffer
// to empty in one cycle.
module rob_banked_multi #(
  parameter int DEPTH          = 32,
  parameter int DISPATCH_WIDTH = 4,
  parameter int RETIRE_WIDTH   = 4,
  parameter int WB_PORTS       = 4,
  parameter int PAYLOAD_W      = 64,
  parameter int IDX_W          = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DISPATCH_WIDTH-1:0]           disp_valid,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] disp_payload,
  output logic                                disp_ready,
  output logic [DISPATCH_WIDTH*IDX_W-1:0]     disp_idx,
  input  logic [WB_PORTS-1:0]                 wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]           wb_idx,
  input  logic [WB_PORTS-1:0]                 wb_exc,
  output logic [RETIRE_WIDTH-1:0]             ret_valid,
  output logic [RETIRE_WIDTH*PAYLOAD_W-1:0]   ret_payload,
  output logic [RETIRE_WIDTH*IDX_W-1:0]       ret_idx,
  input  logic                                ret_ready,
  output logic                                exc_valid,
  output logic [PAYLOAD_W-1:0]                exc_payload,
  input  logic                                flush,
  output logic [IDX_W:0]                      count,
  output logic                                empty,
  output logic                                full
);

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] DISP_CNT  = (IDX_W+1)'(DISPATCH_WIDTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]         head;
  logic [IDX_W:0]         tail;
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       complete_q;
  logic [DEPTH-1:0]       exc_q;
  logic [PAYLOAD_W-1:0]   payload_q [DEPTH];

  logic                   disp_fire;
  logic [IDX_W:0]         n_disp;
  logic [IDX_W:0]         n_ret;
  logic [IDX_W:0]         free_slots;
  logic [IDX_W-1:0]       head_slot;

  assign count      = tail - head;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_CNT);
  assign free_slots = DEPTH_CNT - count;
  // Only registered occupancy is used; a same-cycle retire gives no credit.
  assign disp_ready = (free_slots >= DISP_CNT);
  assign disp_fire  = disp_valid[0] && disp_ready;
  assign n_disp     = (IDX_W+1)'($countones(disp_valid));
  assign n_ret      = (IDX_W+1)'($countones(ret_valid));
  assign head_slot  = head[IDX_W-1:0];

  assign exc_valid   = valid_q[head_slot] && complete_q[head_slot] && exc_q[head_slot];
  assign exc_payload = payload_q[head_slot];

  // Allocation indices for each dispatch lane, wrapping modulo DEPTH.
  always_comb begin
    disp_idx = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      disp_idx[i*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(i);
    end
  end

  // Eligible retire prefix: each lane needs a valid, complete, non-excepting entry and an eligible predecessor.
  always_comb begin
    logic              chain;
    logic [IDX_W-1:0]  slot;
    ret_valid   = '0;
    ret_idx     = '0;
    ret_payload = '0;
    chain       = 1'b1;
    slot        = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      slot  = head_slot + IDX_W'(j);
      chain = chain && valid_q[slot] && complete_q[slot] && !exc_q[slot];
      ret_valid[j]                         = chain;
      ret_idx[j*IDX_W +: IDX_W]            = slot;
      ret_payload[j*PAYLOAD_W +: PAYLOAD_W] = payload_q[slot];
    end
  end

  // Pointer and status-bit update; reset and flush discard the whole cycle's update.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head       <= '0;
      tail       <= '0;
      valid_q    <= '0;
      complete_q <= '0;
      exc_q      <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && valid_q[wb_idx[p*IDX_W +: IDX_W]]) begin
          complete_q[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
          if (wb_exc[p]) begin
            exc_q[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
          end
        end
      end
      if (ret_ready) begin
        for (int j = 0; j < RETIRE_WIDTH; j++) begin
          if (ret_valid[j]) begin
            valid_q[ret_idx[j*IDX_W +: IDX_W]]    <= 1'b0;
            complete_q[ret_idx[j*IDX_W +: IDX_W]] <= 1'b0;
            exc_q[ret_idx[j*IDX_W +: IDX_W]]      <= 1'b0;
          end
        end
        head <= head + n_ret;
      end
      if (disp_fire) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
          if (disp_valid[i]) begin
            valid_q[disp_idx[i*IDX_W +: IDX_W]]    <= 1'b1;
            complete_q[disp_idx[i*IDX_W +: IDX_W]] <= 1'b0;
            exc_q[disp_idx[i*IDX_W +: IDX_W]]      <= 1'b0;
          end
        end
        tail <= tail + n_disp;
      end
    end
  end

  // Payload storage is written only by accepted dispatches and needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush && disp_fire) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (disp_valid[i]) begin
          payload_q[disp_idx[i*IDX_W +: IDX_W]] <= disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_banked_multi.sv
// tb_rob_banked_multi: directed bench for rob_banked_multi with default
// parameters (DEPTH=32, 4 dispatch / retire lanes, 4 writeback ports).
module tb_rob_banked_multi;

  localparam int DEPTH = 32;
  localparam int DW    = 4;
  localparam int RW    = 4;
  localparam int WB    = 4;
  localparam int PW    = 64;
  localparam int IW    = 5;

  logic              clk;
  logic              reset;
  logic [DW-1:0]     disp_valid;
  logic [DW*PW-1:0]  disp_payload;
  logic              disp_ready;
  logic [DW*IW-1:0]  disp_idx;
  logic [WB-1:0]     wb_valid;
  logic [WB*IW-1:0]  wb_idx;
  logic [WB-1:0]     wb_exc;
  logic [RW-1:0]     ret_valid;
  logic [RW*PW-1:0]  ret_payload;
  logic [RW*IW-1:0]  ret_idx;
  logic              ret_ready;
  logic              exc_valid;
  logic [PW-1:0]     exc_payload;
  logic              flush;
  logic [IW:0]       count;
  logic              empty;
  logic              full;

  int tests_run;
  int tests_failed;

  rob_banked_multi #(
    .DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .RETIRE_WIDTH(RW),
    .WB_PORTS(WB), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_exc(wb_exc),
    .ret_valid(ret_valid), .ret_payload(ret_payload), .ret_idx(ret_idx),
    .ret_ready(ret_ready),
    .exc_valid(exc_valid), .exc_payload(exc_payload),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then return inputs to idle; lane i payload = pbase + i.
  task automatic applyStimulus(input logic [DW-1:0] dv, input logic [63:0] pbase,
                               input logic [WB-1:0] wbv, input logic [WB*IW-1:0] wbi,
                               input logic [WB-1:0] wbe, input logic rr, input logic fl);
    disp_valid = dv;
    for (int i = 0; i < DW; i++) disp_payload[i*PW +: PW] = pbase + 64'(i);
    wb_valid  = wbv;
    wb_idx    = wbi;
    wb_exc    = wbe;
    ret_ready = rr;
    flush     = fl;
    @(posedge clk);
    #1;
    disp_valid   = '0;
    disp_payload = '0;
    wb_valid     = '0;
    wb_idx       = '0;
    wb_exc       = '0;
    ret_ready    = 1'b0;
    flush        = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    disp_valid   = '0;
    disp_payload = '0;
    wb_valid     = '0;
    wb_idx       = '0;
    wb_exc       = '0;
    ret_ready    = 1'b0;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    checkOutput("rst_disp_ready", 64'(disp_ready), 64'd1);
    checkOutput("rst_ret_valid",  64'(ret_valid),  64'd0);
    checkOutput("rst_exc_valid",  64'(exc_valid),  64'd0);
    checkOutput("rst_count",      64'(count),      64'd0);
    checkOutput("rst_empty",      64'(empty),      64'd1);
    checkOutput("rst_full",       64'(full),       64'd0);
    checkOutput("rst_disp_idx",   64'(disp_idx),   64'({5'd3, 5'd2, 5'd1, 5'd0}));

    // Fill: 8 cycles x 4 lanes, then a ninth dispatch must be dropped
    for (int k = 0; k < 8; k++) applyStimulus(4'b1111, 64'h1000 + 64'(k*4), '0, '0, '0, 1'b0, 1'b0);
    checkOutput("fill_count",      64'(count),      64'd32);
    checkOutput("fill_full",       64'(full),       64'd1);
    checkOutput("fill_disp_ready", 64'(disp_ready), 64'd0);
    applyStimulus(4'b1111, 64'h9999, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("drop_count",    64'(count),    64'd32);
    checkOutput("drop_disp_idx", 64'(disp_idx), 64'({5'd3, 5'd2, 5'd1, 5'd0}));
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("flush1_empty", 64'(empty), 64'd1);

    // Out-of-order completion: 3,1,2 then 0
    applyStimulus(4'b1111, 64'h100, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 4'b0111, {5'd0, 5'd2, 5'd1, 5'd3}, '0, 1'b0, 1'b0);
    checkOutput("ooo_ret_valid_none", 64'(ret_valid), 64'b0000);
    applyStimulus('0, '0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0}, '0, 1'b0, 1'b0);
    checkOutput("ooo_ret_valid_all", 64'(ret_valid), 64'b1111);
    checkOutput("ooo_ret_idx",       64'(ret_idx),   64'({5'd3, 5'd2, 5'd1, 5'd0}));
    checkOutput("ooo_ret_payload2",  ret_payload[2*PW +: PW], 64'h102);
    applyStimulus('0, '0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("ooo_empty_after_retire", 64'(empty), 64'd1);

    // Gap in completion blocks younger entries
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus(4'b0111, 64'h150, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 4'b0011, {5'd0, 5'd0, 5'd2, 5'd0}, '0, 1'b0, 1'b0);
    checkOutput("gap_ret_valid", 64'(ret_valid), 64'b0001);
    applyStimulus('0, '0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("gap_ret_valid_blocked", 64'(ret_valid), 64'b0000);
    checkOutput("gap_count",             64'(count),     64'd2);
    applyStimulus('0, '0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, '0, 1'b0, 1'b0);
    checkOutput("gap_ret_valid_resume", 64'(ret_valid),     64'b0011);
    checkOutput("gap_ret_idx",          64'(ret_idx[9:0]),  64'({5'd2, 5'd1}));

    // Precise exception on idx 1
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus(4'b0111, 64'h200, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 4'b0111, {5'd0, 5'd2, 5'd0, 5'd1}, 4'b0001, 1'b0, 1'b0);
    checkOutput("exc_c1_ret_valid", 64'(ret_valid), 64'b0001);
    checkOutput("exc_c1_exc_valid", 64'(exc_valid), 64'd0);
    applyStimulus('0, '0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("exc_c2_exc_valid",   64'(exc_valid), 64'd1);
    checkOutput("exc_c2_exc_payload", exc_payload,    64'h201);
    checkOutput("exc_c2_ret_valid",   64'(ret_valid), 64'b0000);
    applyStimulus('0, '0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("exc_hold_count",     64'(count),     64'd2);
    checkOutput("exc_hold_exc_valid", 64'(exc_valid), 64'd1);
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("exc_flush_count",     64'(count),     64'd0);
    checkOutput("exc_flush_exc_valid", 64'(exc_valid), 64'd0);

    // Wrap: move head and tail to 30, then dispatch across the wrap point
    for (int k = 0; k < 7; k++) applyStimulus(4'b1111, 64'(k*4), '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 64'd28, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("wrap_pre_count", 64'(count), 64'd30);
    for (int k = 0; k < 8; k++)
      applyStimulus('0, '0, 4'b1111,
                    {5'(k*4+3), 5'(k*4+2), 5'(k*4+1), 5'(k*4)}, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus('0, '0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("wrap_drained_empty", 64'(empty),    64'd1);
    checkOutput("wrap_disp_idx",      64'(disp_idx), 64'({5'd1, 5'd0, 5'd31, 5'd30}));
    applyStimulus(4'b1111, 64'h300, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("wrap_count_after_disp", 64'(count),     64'd4);
    checkOutput("wrap_fresh_not_done",   64'(ret_valid), 64'b0000);
    applyStimulus('0, '0, 4'b1111, {5'd1, 5'd0, 5'd31, 5'd30}, '0, 1'b0, 1'b0);
    checkOutput("wrap_ret_valid",   64'(ret_valid), 64'b1111);
    checkOutput("wrap_ret_idx",     64'(ret_idx),   64'({5'd1, 5'd0, 5'd31, 5'd30}));
    checkOutput("wrap_ret_payload3", ret_payload[3*PW +: PW], 64'h303);
    applyStimulus('0, '0, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("wrap_post_count",    64'(count),    64'd0);
    checkOutput("wrap_post_empty",    64'(empty),    64'd1);
    checkOutput("wrap_post_full",     64'(full),     64'd0);
    checkOutput("wrap_post_disp_idx", 64'(disp_idx), 64'({5'd5, 5'd4, 5'd3, 5'd2}));

    // Simultaneous dispatch 4 and retire 4 at count 28
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) applyStimulus(4'b1111, 64'h400 + 64'(k*4), '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, 4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, '0, 1'b0, 1'b0);
    checkOutput("sim_pre_count",      64'(count),      64'd28);
    checkOutput("sim_pre_disp_ready", 64'(disp_ready), 64'd1);
    checkOutput("sim_pre_ret_valid",  64'(ret_valid),  64'b1111);
    applyStimulus(4'b1111, 64'h500, '0, '0, '0, 1'b1, 1'b0);
    checkOutput("sim_count",      64'(count),      64'd28);
    checkOutput("sim_disp_ready", 64'(disp_ready), 64'd1);
    checkOutput("sim_disp_idx",   64'(disp_idx),   64'({5'd3, 5'd2, 5'd1, 5'd0}));
    checkOutput("sim_ret_valid",  64'(ret_valid),  64'b0000);

    // Flush beats a same-cycle dispatch; reset does the same
    applyStimulus(4'b1111, 64'h600, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("flush_prio_count", 64'(count), 64'd0);
    applyStimulus(4'b1111, 64'h700, '0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(4'b0011, 64'h800, 4'b0001, '0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("reset_prio_count",    64'(count),    64'd0);
    checkOutput("reset_prio_disp_idx", 64'(disp_idx), 64'({5'd3, 5'd2, 5'd1, 5'd0}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
